rx_frame_assembler: RTL
=======================

# rx_frame_assembler

Parametrised framing stage between the UART receiver and the ALU. It assembles a frame of optional sync byte, operand A, operand B and opcode from the receiver's byte stream, with operands wider than one UART byte. It delivers A, B and opcode to the ALU through a valid/ready handshake. Partial frames are dropped on inter-byte timeout, and bytes that arrive while a result is pending are flagged as overruns.

## Interface
- NB_DATA, 8: UART byte width.
- NB_OPERAND, 16: operand width; must be an integer multiple of NB_DATA. BYTES = NB_OPERAND/NB_DATA.
- NB_OPCODE, 6: opcode width; must be ≤ NB_DATA.
- SYNC_EN, 1: 1 = a frame must start with SYNC_BYTE; 0 = no sync byte.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 100000: maximum idle cycles allowed inside a frame; 0 disables the timeout.
- NB_TIMER, 17: timer width; must satisfy 2^NB_TIMER > TIMEOUT_CYCLES.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low; clock i_clk.
- i_data  in  NB_DATA  received byte; valid while i_done_data is high.
- i_done_data  in  1  byte-ready level from the receiver; only its rising edge counts.
- i_ready  in  1  ALU accepts the frame.
- o_a  out  NB_OPERAND  operand A.
- o_b  out  NB_OPERAND  operand B.
- o_op  out  NB_OPCODE  opcode.
- o_valid  out  1  frame available; held high until accepted.
- o_frame_err  out  1  one-cycle pulse on timeout or overrun.
- o_busy  out  1  a partial frame is in progress.

## Operation
- Byte event: ev = i_done_data & ~done_prev. done_prev is registered, and its reset value is 0. A level held high for any number of cycles produces exactly one event.
- START state = IDLE if SYNC_EN=1, otherwise RX_A.
- States: IDLE, RX_A, RX_B, RX_OP, HOLD. A 2-bit-plus byte counter, cnt (0..BYTES-1), indexes the current operand byte.
- IDLE: on ev with i_data==SYNC_BYTE, go to RX_A with cnt=0. Any other byte is ignored silently, with no error.
- RX_A: on ev, write i_data into shadow_a[cnt*NB_DATA +: NB_DATA]. Byte order is little-endian: the first byte is the LSB. When cnt==BYTES-1, clear cnt and go to RX_B; otherwise increment cnt.
- RX_B: same as RX_A, writing into shadow_b, then go to RX_OP.
- RX_OP: on ev, load o_a←shadow_a, o_b←shadow_b and o_op←i_data[NB_OPCODE-1:0] together, then go to HOLD.
- Outputs change only at frame completion. Partial frames never disturb o_a, o_b or o_op.
- HOLD: o_valid=1. When i_ready=1, go to START.
- Overrun: ev in HOLD drops the byte and pulses o_frame_err. If ev and i_ready occur in the same cycle, both take effect: the byte is dropped, the error pulses, and the state goes to START.
- Partial frame = state RX_B or RX_OP; or RX_A with SYNC_EN=1; or RX_A with cnt≠0. o_busy = partial frame.
- Timer: cleared on every ev and whenever there is no partial frame. It increments each cycle while a partial frame is in progress.
- Timeout: if TIMEOUT_CYCLES≠0 and timer==TIMEOUT_CYCLES-1 with no ev, then:
  - clear cnt and the timer;
  - go to START;
  - pulse o_frame_err.
  - The shadows are not cleared; the next frame overwrites them.
- If ev and timeout expiry occur in the same cycle, ev wins: the byte is accepted and the timer is cleared.
- Reset mid-operation discards everything, including any pending o_valid.

## Timing
- Reset values:
  - o_a, o_b, o_op = 0.
  - o_valid, o_frame_err, o_busy = 0.
  - state = START; cnt, timer, done_prev = 0.
- All outputs are registered.
- Latency: o_valid and the new o_a/o_b/o_op appear 1 cycle after the first cycle in which the opcode byte's i_done_data is sampled high.
- Handshake: the frame transfers on the clock edge where o_valid & i_ready. o_valid is low the next cycle.
- o_a, o_b and o_op stay stable from o_valid high until the next frame completes.
- Back-to-back frames are allowed. With SYNC_EN=0, the first byte after acceptance starts RX_A; a byte arriving while o_valid is still high is an overrun.
- o_frame_err is high for exactly 1 cycle per error event.

## Test plan
- Basic frame, NB_OPERAND=16, SYNC_EN=1: bytes A5,34,12,78,56,05 -> o_a=16'h1234, o_b=16'h5678, o_op=6'h05, o_valid 1 cycle after the last byte. o_valid holds for 10 cycles while i_ready=0 and drops 1 cycle after i_ready=1.
- Sync hunt and edge detection: bytes 00,FF, then A5. i_done_data is held high 5 cycles per byte. -> 00 and FF ignored with no error; each byte counted once; the frame completes normally.
- Timeout, TIMEOUT_CYCLES=20: send A5,34, then idle 20 cycles -> o_frame_err pulse, o_busy=0. A following full frame A5,11,00,22,00,01 -> o_a=16'h0011, o_b=16'h0022.
- Overrun: during HOLD, send byte 99 with i_ready=0 -> o_frame_err pulse; outputs unchanged; o_valid still 1.
- Reset mid-frame: assert i_rst low after A5,34,12 -> all outputs 0. After release, a clean frame is received correctly.
- Parameter sweep: NB_OPERAND=8 (BYTES=1) and 32 (BYTES=4), SYNC_EN=0. Random frames checked against a reference model.

Source files
------------

// File: rtl/rx_frame_assembler.sv
// Assembles {sync, A[BYTES], B[BYTES], opcode} from a UART byte stream into one ALU frame.
// Latency: o_valid/o_a/o_b/o_op register one cycle after the opcode byte's rising i_done_data.
// Backpressure: frame held on o_valid until i_ready; bytes arriving meanwhile are dropped with o_frame_err.
module rx_frame_assembler #(
    parameter int                  NB_DATA        = 8,
    parameter int                  NB_OPERAND     = 16,
    parameter int                  NB_OPCODE      = 6,
    parameter bit                  SYNC_EN        = 1'b1,
    parameter logic [NB_DATA-1:0]  SYNC_BYTE      = 8'hA5,
    parameter int                  TIMEOUT_CYCLES = 100000,
    parameter int                  NB_TIMER       = 17
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NB_DATA-1:0]     i_data,
    input  logic                   i_done_data,
    input  logic                   i_ready,
    output logic [NB_OPERAND-1:0]  o_a,
    output logic [NB_OPERAND-1:0]  o_b,
    output logic [NB_OPCODE-1:0]   o_op,
    output logic                   o_valid,
    output logic                   o_frame_err,
    output logic                   o_busy
);

    localparam int BYTES  = NB_OPERAND / NB_DATA;
    localparam int NB_CNT = $clog2(BYTES) + 2;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [NB_TIMER-1:0] TMO_LAST = NB_TIMER'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RX_A, RX_B, RX_OP, HOLD} state_t;

    // Without a sync byte the first byte of a frame is already operand A.
    localparam state_t START = state_t'(SYNC_EN ? IDLE : RX_A);

    // A frame is partial once it has consumed at least one byte and is not yet complete.
    function automatic logic partial_f(input state_t s, input logic [NB_CNT-1:0] c);
        return (s == RX_B) || (s == RX_OP) || ((s == RX_A) && (SYNC_EN || (c != '0)));
    endfunction

    state_t                 state_q, state_d;
    logic [NB_CNT-1:0]      cnt_q, cnt_d;
    logic [NB_TIMER-1:0]    timer_q, timer_d;
    logic [NB_OPERAND-1:0]  shadow_a_q, shadow_a_d;
    logic [NB_OPERAND-1:0]  shadow_b_q, shadow_b_d;
    logic [NB_OPERAND-1:0]  a_q, a_d;
    logic [NB_OPERAND-1:0]  b_q, b_d;
    logic [NB_OPCODE-1:0]   op_q, op_d;
    logic                   valid_q, err_q, err_d, busy_q, done_prev_q;

    logic ev;
    logic last_byte;
    logic timeout_hit;

    assign ev        = i_done_data & ~done_prev_q;
    assign last_byte = (cnt_q == NB_CNT'(BYTES - 1));
    // busy_q is the registered partial-frame flag of the current state.
    assign timeout_hit = TMO_EN && busy_q && !ev && (timer_q == TMO_LAST);

    // Next-state, shadow capture, output load, error and inter-byte timer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev && (i_data == SYNC_BYTE)) begin
                    state_d = RX_A;
                    cnt_d   = '0;
                end
            end
            RX_A: begin
                if (ev) begin
                    for (int i = 0; i < BYTES; i++)
                        if (cnt_q == NB_CNT'(i)) shadow_a_d[i*NB_DATA +: NB_DATA] = i_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = RX_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RX_B: begin
                if (ev) begin
                    for (int i = 0; i < BYTES; i++)
                        if (cnt_q == NB_CNT'(i)) shadow_b_d[i*NB_DATA +: NB_DATA] = i_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = RX_OP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RX_OP: begin
                if (ev) begin
                    a_d     = shadow_a_q;
                    b_d     = shadow_b_q;
                    op_d    = i_data[NB_OPCODE-1:0];
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A byte here is an overrun; acceptance still proceeds in the same cycle.
                err_d = ev;
                if (i_ready) state_d = START;
            end
            default: begin
                state_d = START;
                cnt_d   = '0;
            end
        endcase
        // Stalled partial frame: abandon it, shadows are simply overwritten later.
        if (timeout_hit) begin
            state_d = START;
            cnt_d   = '0;
            err_d   = 1'b1;
        end
        if (ev || !busy_q || timeout_hit) timer_d = '0;
        else                              timer_d = timer_q + 1'b1;
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= START;
            cnt_q       <= '0;
            timer_q     <= '0;
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            shadow_a_q  <= shadow_a_d;
            shadow_b_q  <= shadow_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            valid_q     <= (state_d == HOLD);
            err_q       <= err_d;
            busy_q      <= partial_f(state_d, cnt_d);
            done_prev_q <= i_done_data;
        end
    end

    assign o_a         = a_q;
    assign o_b         = b_q;
    assign o_op        = op_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = busy_q;

endmodule
